imem_prog_loader: RTL

//   Writer side of the instruction memory: receives a framed byte stream (UART/debug link),

---
 rtl/imem_prog_loader_if.sv | 57 +++++
 rtl/imem_prog_loader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/imem_prog_loader_if.sv
// -----------------------------------------------------------------------------
// imem_prog_loader_if
//   Groups the byte-stream input and the instruction-memory write / core-control
//   outputs of the program loader into one bundle.
//
//   Signals
//     rx_valid    byte source -> loader : rx_data holds a byte
//     rx_data     byte source -> loader : incoming byte
//     rx_ready    loader -> byte source : byte taken when rx_valid & rx_ready
//     imem_we     loader -> imem        : one-cycle write strobe
//     imem_addr   loader -> imem        : word address of write
//     imem_wdata  loader -> imem        : 32-bit instruction word
//     cpu_rst     loader -> core        : 1 = hold core in reset
//     load_done   loader -> system      : frame accepted, checksum good (sticky)
//     err         loader -> system      : last frame had bad length or checksum
//
//   Modports
//     slave  : the loader itself
//     master : the byte source / surrounding system
// -----------------------------------------------------------------------------
interface imem_prog_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_rst;
    logic                  load_done;
    logic                  err;

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output cpu_rst,
        output load_done,
        output err
    );

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  cpu_rst,
        input  load_done,
        input  err
    );
endinterface

// File: rtl/imem_prog_loader.sv
// -----------------------------------------------------------------------------
// imem_prog_loader
//   Writer side of the instruction memory. Receives a framed byte stream
//     HEADER, N (words), 4*N data bytes (LSB first per word), CHK (XOR of data)
//   assembles little-endian 32-bit words, writes them to imem from address 0
//   and releases the core from reset only after a frame passes its checksum.
//
//   Ports
//     clk   : system clock, rising edge
//     rst   : synchronous active-high reset
//     link  : imem_prog_loader_if.slave (rx handshake, imem write port,
//             cpu_rst / load_done / err status); all outputs registered
//
//   Parameters
//     ADDR_WIDTH : imem word-address width, frame length N <= 2**ADDR_WIDTH
//     HEADER     : frame start byte
// -----------------------------------------------------------------------------
module imem_prog_loader #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] HEADER     = 8'hA5
) (
    input logic                    clk,
    input logic                    rst,
    imem_prog_loader_if.slave      link
);

    // Counter width wide enough to hold both N (8 bits) and 2**ADDR_WIDTH.
    localparam int CW = (ADDR_WIDTH + 1 > 9) ? ADDR_WIDTH + 1 : 9;
    localparam logic [CW-1:0] MAX_WORDS = CW'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            len_q, len_d;
    logic [1:0]            lane_q, lane_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [7:0]            xor_q, xor_d;
    logic [23:0]           word_q, word_d;     // lower three bytes of the word in flight

    logic                  rx_ready_q, rx_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  load_done_q, load_done_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  len_ok;
    logic                  last_word;

    assign accept    = link.rx_valid & rx_ready_q;
    assign len_ok    = (link.rx_data != 8'h00) && (CW'(link.rx_data) <= MAX_WORDS);
    assign last_word = (CW'(idx_q) + CW'(1)) == CW'(len_q);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        lane_d       = lane_q;
        idx_d        = idx_q;
        xor_d        = xor_q;
        word_d       = word_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (link.rx_data == HEADER) begin
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if (len_ok) begin
                        len_d   = link.rx_data;
                        lane_d  = '0;
                        idx_d   = '0;
                        xor_d   = '0;
                        word_d  = '0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
                S_DATA: begin
                    xor_d  = xor_q ^ link.rx_data;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: word_d[7:0]   = link.rx_data;
                        2'd1: word_d[15:8]  = link.rx_data;
                        2'd2: word_d[23:16] = link.rx_data;
                        default: begin
                            // Top byte completes the word: write it straight out.
                            imem_we_d    = 1'b1;
                            imem_addr_d  = idx_q;
                            imem_wdata_d = {link.rx_data, word_q};
                            idx_d        = idx_q + ADDR_WIDTH'(1);
                            if (last_word) begin
                                state_d = S_CHK;
                            end
                        end
                    endcase
                end
                S_CHK: begin
                    state_d = (link.rx_data == xor_q) ? S_DONE : S_ERROR;
                end
                S_ERROR: begin
                    if (link.rx_data == HEADER) begin
                        state_d = S_LEN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        // Status outputs are registered copies of the next state's status.
        rx_ready_d  = (state_d != S_DONE);
        cpu_rst_d   = (state_d != S_DONE);
        load_done_d = (state_d == S_DONE);
        err_d       = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            lane_q       <= '0;
            idx_q        <= '0;
            xor_q        <= '0;
            word_q       <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            load_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            lane_q       <= lane_d;
            idx_q        <= idx_d;
            xor_q        <= xor_d;
            word_q       <= word_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            load_done_q  <= load_done_d;
            err_q        <= err_d;
        end
    end

    assign link.rx_ready   = rx_ready_q;
    assign link.imem_we    = imem_we_q;
    assign link.imem_addr  = imem_addr_q;
    assign link.imem_wdata = imem_wdata_q;
    assign link.cpu_rst    = cpu_rst_q;
    assign link.load_done  = load_done_q;
    assign link.err        = err_q;

endmodule
